layer_serializer: RTL and testbench

Parallel-to-serial front end for the sequential layer pipeline. Accepts one full activation vector of `NUM_WORDS` words via a valid-ready handshake, then emits the words one per accepted transfer, lowest word first, on a registered valid-ready output stream. It sits between a parallel-output layer and per-word streaming layers such as the ReLU stage. It is a helpful producer and consumer: a new vector can be loaded in the same cycle the last word of the previous vector leaves, so back-to-back vectors stream without a bubble.

---
 rtl/layer_serializer.sv | 96 +++++++++
 tb/tb_layer_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
// Parallel-to-serial front end: loads a full activation vector in one handshake,
// then streams its words out lowest first on a registered valid/ready port.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no words pending, ready for a new vector
// BUSY  | buffer holds words, low word presented on data_r_o
module layer_serializer #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_WORDS = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    output logic                           ready_o,
    input  logic                           valid_i,
    input  logic [NUM_WORDS*WORD_SIZE-1:0] data_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic signed [WORD_SIZE-1:0]    data_r_o,
    output logic                           last_o
);

    localparam int CW = $clog2(NUM_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_WORDS*WORD_SIZE-1:0] buf_q, buf_d;
    logic [CW-1:0]                  count_q, count_d;
    logic                           last_q, last_d;
    logic                           in_xfer;
    logic                           out_xfer;

    // The last word leaving frees the buffer in the same cycle, so a new vector
    // may load then; this is the only combinational ready_i -> ready_o path.
    assign ready_o  = !reset_i &&
                      ((state_q == EMPTY) || ((state_q == BUSY) && last_q && ready_i));
    assign valid_o  = (state_q == BUSY);
    assign last_o   = last_q;
    assign data_r_o = $signed(buf_q[WORD_SIZE-1:0]);

    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

    // Next-state, buffer shift/load and word counter.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    buf_d   = data_i;
                    count_d = '0;
                end
            end
            BUSY: begin
                if (out_xfer) begin
                    if (!last_q) begin
                        buf_d   = buf_q >> WORD_SIZE;
                        count_d = count_q + CW'(1);
                    end else if (in_xfer) begin
                        buf_d   = data_i;
                        count_d = '0;
                    end else begin
                        // buffer keeps its stale low word; don't-care with valid_o low
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        last_d = (state_d == BUSY) && (count_d == LAST_IDX);
    end

    // State, buffer and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            buf_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge, and expected words are
// queued when a vector is accepted and popped when a word transfers out.
module tb_layer_serializer;

    localparam int WS = 16;
    localparam int NW = 8;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic                 ready_o;
    logic                 valid_i;
    logic [NW*WS-1:0]     data_i;
    logic                 valid_o;
    logic                 ready_i;
    logic signed [WS-1:0] data_r_o;
    logic                 last_o;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [WS-1:0] w;
        logic          l;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    layer_serializer #(.WORD_SIZE(WS), .NUM_WORDS(NW)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .ready_o  (ready_o),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_r_o (data_r_o),
        .last_o   (last_o)
    );

    function automatic logic [NW*WS-1:0] seq_vec(input logic [WS-1:0] base);
        logic [NW*WS-1:0] r;
        for (int k = 0; k < NW; k++) r[k*WS +: WS] = base + WS'(k);
        return r;
    endfunction

    function automatic void push_vec(input logic [NW*WS-1:0] v);
        exp_t x;
        for (int k = 0; k < NW; k++) begin
            x.w = v[k*WS +: WS];
            x.l = (k == NW - 1);
            sb.push_back(x);
        end
    endfunction

    task automatic test_reset();
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0) $display("FAIL reset_ready_during got=%b exp=0", ready_o);
        else passed++;
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else passed++;
        checks++;
        if (last_o !== 1'b0) $display("FAIL reset_last got=%b exp=0", last_o); else passed++;
        checks++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready_o); else passed++;
        checks++;
        if (data_r_o !== 16'sh0000) $display("FAIL reset_data got=%h exp=0000", data_r_o); else passed++;
        @(posedge clk); #1;
    endtask

    // One vector with ready_i held high; used for the basic and signed cases.
    task automatic test_stream(input string tag, input logic [NW*WS-1:0] vec);
        int n_out = 0;
        valid_i = 1'b1; data_i = vec; ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL %s_load ready/valid got=%b/%b exp=1/0", tag, ready_o, valid_o);
        else passed++;
        if (valid_i && ready_o) push_vec(data_i);
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int c = 1; c <= NW; c++) begin
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b1) $display("FAIL %s_valid cycle %0d got=%b exp=1", tag, c, valid_o);
            else passed++;
            if (valid_o && ready_i) begin
                checks++;
                n_out++;
                if (sb.size() == 0) $display("FAIL %s_word unexpected got=%h", tag, data_r_o);
                else begin
                    e = sb.pop_front();
                    if (data_r_o !== e.w || last_o !== e.l)
                        $display("FAIL %s_word got=%h/%b exp=%h/%b", tag, data_r_o, last_o, e.w, e.l);
                    else passed++;
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || sb.size() != 0 || n_out != NW)
            $display("FAIL %s_end valid=%b ready=%b left=%0d words=%0d exp valid=0 ready=1 left=0 words=%0d",
                     tag, valid_o, ready_o, sb.size(), n_out, NW);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int   n_out = 0;
        logic prev_stall = 1'b0;
        logic [WS-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        valid_i = 1'b1; data_i = seq_vec(16'h0001); ready_i = 1'b1;
        @(negedge clk);
        if (valid_i && ready_o) push_vec(data_i);
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int c = 1; c < 40 && n_out < NW; c++) begin
            ready_i = (c % 3 == 1);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (valid_o !== 1'b1 || data_r_o !== prev_data || last_o !== prev_last)
                    $display("FAIL bp_hold cycle %0d got=%b/%h/%b exp=1/%h/%b",
                             c, valid_o, data_r_o, last_o, prev_data, prev_last);
                else passed++;
            end
            if (valid_o && ready_i) begin
                checks++;
                n_out++;
                if (sb.size() == 0) $display("FAIL bp_word unexpected got=%h", data_r_o);
                else begin
                    e = sb.pop_front();
                    if (data_r_o !== e.w || last_o !== e.l)
                        $display("FAIL bp_word got=%h/%b exp=%h/%b", data_r_o, last_o, e.w, e.l);
                    else passed++;
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_data  = data_r_o;
            prev_last  = last_o;
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (n_out != NW || sb.size() != 0 || valid_o !== 1'b0)
            $display("FAIL bp_count words=%0d left=%0d valid=%b exp words=%0d left=0 valid=0",
                     n_out, sb.size(), valid_o, NW);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int   n_out = 0;
        int   accepted = 0;
        logic exp_rdy;
        valid_i = 1'b1; data_i = seq_vec(16'h0A00); ready_i = 1'b1;
        for (int c = 0; c <= 2*NW; c++) begin
            @(negedge clk);
            exp_rdy = (c == 0 || c == NW);
            if (c < 2*NW) begin
                checks++;
                if (ready_o !== exp_rdy) $display("FAIL b2b_ready cycle %0d got=%b exp=%b", c, ready_o, exp_rdy);
                else passed++;
            end
            if (c >= 1) begin
                checks++;
                if (valid_o !== 1'b1) $display("FAIL b2b_gap cycle %0d got=%b exp=1", c, valid_o);
                else passed++;
            end
            if (valid_i && ready_o) begin
                push_vec(data_i);
                accepted++;
            end
            if (valid_o && ready_i) begin
                checks++;
                n_out++;
                if (sb.size() == 0) $display("FAIL b2b_word unexpected got=%h", data_r_o);
                else begin
                    e = sb.pop_front();
                    if (data_r_o !== e.w || last_o !== e.l)
                        $display("FAIL b2b_word got=%h/%b exp=%h/%b", data_r_o, last_o, e.w, e.l);
                    else passed++;
                end
            end
            @(posedge clk); #1;
            if (accepted == 1) data_i = seq_vec(16'h0B00);
            if (accepted >= 2) valid_i = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || sb.size() != 0 || n_out != 2*NW)
            $display("FAIL b2b_end valid=%b left=%0d words=%0d exp valid=0 left=0 words=%0d",
                     valid_o, sb.size(), n_out, 2*NW);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int n_out = 0;
        int accepted_c = 0;
        ready_i = 1'b1;
        for (int c = 0; c <= 2*NW; c++) begin
            if (c == 0) begin
                valid_i = 1'b1; data_i = seq_vec(16'h0A00);
            end else if (c >= 2 && c <= NW) begin
                valid_i = 1'b1; data_i = seq_vec(16'h0C00);
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            if (c >= 2 && c <= NW - 1) begin
                checks++;
                if (ready_o !== 1'b0) $display("FAIL busy_ready cycle %0d got=%b exp=0", c, ready_o);
                else passed++;
            end
            if (valid_i && ready_o) begin
                push_vec(data_i);
                if (c != 0) accepted_c = c;
            end
            if (valid_o && ready_i) begin
                checks++;
                n_out++;
                if (sb.size() == 0) $display("FAIL busy_word unexpected got=%h", data_r_o);
                else begin
                    e = sb.pop_front();
                    if (data_r_o !== e.w || last_o !== e.l)
                        $display("FAIL busy_word got=%h/%b exp=%h/%b", data_r_o, last_o, e.w, e.l);
                    else passed++;
                end
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (accepted_c != NW || n_out != 2*NW || sb.size() != 0)
            $display("FAIL busy_accept cycle=%0d words=%0d left=%0d exp cycle=%0d words=%0d left=0",
                     accepted_c, n_out, sb.size(), NW, 2*NW);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n_out = 0;
        ready_i = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            valid_i = (c == 0); data_i = seq_vec(16'h0A00);
            @(negedge clk);
            if (valid_i && ready_o) push_vec(data_i);
            if (valid_o && ready_i) begin
                checks++;
                if (sb.size() == 0) $display("FAIL rmid_word unexpected got=%h", data_r_o);
                else begin
                    e = sb.pop_front();
                    if (data_r_o !== e.w || last_o !== e.l)
                        $display("FAIL rmid_word got=%h/%b exp=%h/%b", data_r_o, last_o, e.w, e.l);
                    else passed++;
                end
            end
            @(posedge clk); #1;
        end
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0) $display("FAIL rmid_ready_in_reset got=%b exp=0", ready_o); else passed++;
        @(posedge clk); #1;
        sb.delete();
        reset_i = 1'b0; valid_i = 1'b1; data_i = seq_vec(16'h0D00); ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || data_r_o !== 16'sh0000 || last_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL rmid_after valid/data/last/ready got=%b/%h/%b/%b exp=0/0000/0/1",
                     valid_o, data_r_o, last_o, ready_o);
        else passed++;
        if (valid_i && ready_o) push_vec(data_i);
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int c = 1; c <= NW; c++) begin
            @(negedge clk);
            if (valid_o && ready_i) begin
                checks++;
                n_out++;
                if (sb.size() == 0) $display("FAIL rmid_new unexpected got=%h", data_r_o);
                else begin
                    e = sb.pop_front();
                    if (data_r_o !== e.w || last_o !== e.l)
                        $display("FAIL rmid_new got=%h/%b exp=%h/%b", data_r_o, last_o, e.w, e.l);
                    else passed++;
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (n_out != NW || sb.size() != 0 || valid_o !== 1'b0)
            $display("FAIL rmid_count words=%0d left=%0d valid=%b exp words=%0d left=0 valid=0",
                     n_out, sb.size(), valid_o, NW);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d passed=%0d", checks, passed);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NW*WS-1:0] sv;
        sv = {16'h1234, 16'hFFFE, 16'h0001, 16'h8001, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
        test_reset();
        test_stream("basic", seq_vec(16'h0001));
        test_backpressure();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_stream("signed", sv);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
